// File: rtl/dram_ring_pkg.sv
// Shared types and constants for the DRAM ring-buffer command arbiter.
// State encoding is visible on the debug port, so the values are fixed.
package dram_ring_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    RD_CMD   = 3'd2,
    RD_WAIT  = 3'd3,
    TURN     = 3'd4
  } state_t;

  localparam int ADDR_W_DEF    = 24;
  localparam int BURST_LEN_DEF = 4;

  localparam logic CMD_RD = 1'b1;
  localparam logic CMD_WR = 1'b0;

endpackage

// File: rtl/dram_ring_wptr.sv
// Ring write pointer: wraps naturally at 2^ADDR_W, and flags a read
// address that has caught up with the next word to be written.
module dram_ring_wptr
  import dram_ring_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              empty
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (inc) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
    end
  end

  assign empty = (rd_addr == wr_ptr);

endmodule

// File: rtl/dram_ring_arbiter.sv
// Shares the ring DRAM command port between capture write bursts and
// single-word BRAM-fill reads. Build with DRAM_RD_TIMEOUT_EN for rd_err.
module dram_ring_arbiter
  import dram_ring_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int WR_HI_WATER = 8,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [7:0]        wr_fill,
  output logic              wr_pop,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              rd_done,
  output logic              rd_empty,
  output logic              dram_cmd_valid,
  output logic              dram_cmd_rnw,
  output logic [ADDR_W-1:0] dram_cmd_addr,
  input  logic              dram_cmd_ready,
  input  logic              dram_rd_valid,
  output logic [ADDR_W-1:0] wr_ptr,
`ifdef DRAM_RD_TIMEOUT_EN
  output logic              rd_err,
`endif
  output logic [2:0]        state
);

  localparam int CNT_W = 5;

  if (BURST_LEN < 1 || BURST_LEN > 16 ||
      (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst
    $error("BURST_LEN must be a power of 2 in 1..16");
  end
  if (RD_TIMEOUT < 1 || RD_TIMEOUT > 255) begin : g_bad_to
    $error("RD_TIMEOUT must be in 1..255");
  end

  state_t            cur_st;
  state_t            nxt_st;
  logic              last_rd;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              hi_water;
  logic              can_rd;
  logic              burst_end;
  logic              timeout;

  dram_ring_wptr #(
    .ADDR_W(ADDR_W)
  ) u_wptr (
    .clk    (clk),
    .rst    (rst),
    .inc    (wr_pop),
    .rd_addr(rd_addr),
    .wr_ptr (wr_ptr),
    .empty  (rd_empty)
  );

  assign hi_water  = (wr_fill >= 8'(WR_HI_WATER));
  assign can_rd    = rd_req && !rd_empty;
  assign wr_pop    = (cur_st == WR_BURST) && dram_cmd_ready;
  assign rd_grant  = (cur_st == RD_CMD) && dram_cmd_ready;
  assign rd_done   = (cur_st == RD_WAIT) && dram_rd_valid;
  assign burst_end = wr_pop &&
                     (beat_cnt == CNT_W'(BURST_LEN - 1));

`ifdef DRAM_RD_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // Cleared while the read command is pending, so RD_WAIT starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (cur_st == RD_CMD) begin
      wd_cnt <= '0;
    end else if (cur_st == RD_WAIT) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  assign timeout = (cur_st == RD_WAIT) && !dram_rd_valid &&
                   (wd_cnt == 8'(RD_TIMEOUT));
  assign rd_err  = timeout;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    nxt_st = cur_st;
    unique case (cur_st)
      IDLE: begin
        if (wr_req && hi_water) begin
          nxt_st = WR_BURST;
        end else if (wr_req && can_rd) begin
          nxt_st = last_rd ? WR_BURST : RD_CMD;
        end else if (wr_req) begin
          nxt_st = WR_BURST;
        end else if (can_rd) begin
          nxt_st = RD_CMD;
        end
      end
      WR_BURST: if (burst_end) nxt_st = TURN;
      RD_CMD:   if (rd_grant) nxt_st = RD_WAIT;
      RD_WAIT:  if (rd_done || timeout) nxt_st = TURN;
      TURN:     nxt_st = IDLE;
      default:  nxt_st = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st    <= IDLE;
      last_rd   <= 1'b1;
      beat_cnt  <= '0;
      rd_addr_q <= '0;
    end else begin
      cur_st <= nxt_st;
      if (burst_end) begin
        beat_cnt <= '0;
        last_rd  <= 1'b0;
      end else if (wr_pop) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (rd_grant) begin
        last_rd <= 1'b1;
      end
      if (cur_st == IDLE && nxt_st == RD_CMD) begin
        rd_addr_q <= rd_addr;
      end
    end
  end

  assign dram_cmd_valid = (cur_st == WR_BURST) ||
                          (cur_st == RD_CMD);
  assign dram_cmd_rnw   = (cur_st == RD_CMD) ? CMD_RD : CMD_WR;

  always_comb begin
    dram_cmd_addr = '0;
    unique case (1'b1)
      cur_st == WR_BURST: dram_cmd_addr = wr_ptr;
      cur_st == RD_CMD:   dram_cmd_addr = rd_addr_q;
      default:            dram_cmd_addr = '0;
    endcase
  end

  assign state = cur_st;

endmodule

// File: tb/tb_dram_ring_arbiter.sv
// Directed bench for dram_ring_arbiter with a command scoreboard.
// Define DRAM_RD_TIMEOUT_EN to exercise the read watchdog instead.
module tb_dram_ring_arbiter;
  import dram_ring_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [7:0]    wr_fill;
  logic          wr_pop;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_grant;
  logic          rd_done;
  logic          rd_empty;
  logic          dram_cmd_valid;
  logic          dram_cmd_rnw;
  logic [AW-1:0] dram_cmd_addr;
  logic          dram_cmd_ready;
  logic          dram_rd_valid;
  logic [AW-1:0] wr_ptr;
  logic [2:0]    state;
`ifdef DRAM_RD_TIMEOUT_EN
  logic          rd_err;
`endif

  logic man_valid;
  logic auto_rsp;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [AW:0] exp_q[$];
  logic [AW:0] exp_cmd;
  logic        stall_q = 1'b0;
  logic [AW:0] stall_cmd = '0;

  always #5 clk = ~clk;

  // Auto responder returns read data on the first RD_WAIT cycle.
  assign dram_rd_valid = man_valid |
                         (auto_rsp && state == 3'd3);

  dram_ring_arbiter #(
    .ADDR_W     (AW),
    .BURST_LEN  (4),
    .WR_HI_WATER(8),
    .RD_TIMEOUT (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_req        (wr_req),
    .wr_fill       (wr_fill),
    .wr_pop        (wr_pop),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_grant      (rd_grant),
    .rd_done       (rd_done),
    .rd_empty      (rd_empty),
    .dram_cmd_valid(dram_cmd_valid),
    .dram_cmd_rnw  (dram_cmd_rnw),
    .dram_cmd_addr (dram_cmd_addr),
    .dram_cmd_ready(dram_cmd_ready),
    .dram_rd_valid (dram_rd_valid),
    .wr_ptr        (wr_ptr),
`ifdef DRAM_RD_TIMEOUT_EN
    .rd_err        (rd_err),
`endif
    .state         (state)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_st(input logic [2:0] s,
                         input int budget,
                         input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_wr(input int base);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({CMD_WR, AW'(base + i)});
  endtask

  task automatic push_rd(input int a);
    exp_q.push_back({CMD_RD, AW'(a)});
  endtask

  // Scoreboard and handshake monitor.
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 32'(dram_cmd_valid), 32'd1);
        chk("hold_cmd",
            32'({dram_cmd_rnw, dram_cmd_addr}),
            32'(stall_cmd));
      end
      if (dram_cmd_valid && dram_cmd_ready) begin
        chk("cmd_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_cmd = exp_q.pop_front();
          chk("cmd",
              32'({dram_cmd_rnw, dram_cmd_addr}),
              32'(exp_cmd));
        end
        chk("wr_pop", 32'(wr_pop), 32'(!dram_cmd_rnw));
        chk("rd_grant", 32'(rd_grant), 32'(dram_cmd_rnw));
      end else begin
        chk("no_pulse", 32'({wr_pop, rd_grant}), 32'd0);
      end
      if (wr_pop) pops++;
      stall_q   = dram_cmd_valid && !dram_cmd_ready;
      stall_cmd = {dram_cmd_rnw, dram_cmd_addr};
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    wr_req = 1'b0;
    wr_fill = 8'd0;
    rd_req = 1'b0;
    rd_addr = '0;
    dram_cmd_ready = 1'b0;
    man_valid = 1'b0;
    auto_rsp = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_valid", 32'(dram_cmd_valid), 32'd0);
    chk("rst_addr", 32'(dram_cmd_addr), 32'd0);
    chk("rst_rnw", 32'(dram_cmd_rnw), 32'd0);
    chk("rst_pulses",
        32'({wr_pop, rd_grant, rd_done}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dram_cmd_ready = 1'b1;

    // Write only.
    wr_fill = 8'd4;
    wr_req = 1'b1;
    push_wr(0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    wait_st(TURN, 10, "wr_turn");
    @(negedge clk);
    chk("wr_idle", 32'(state), 32'(IDLE));
    chk("wr_ptr_4", 32'(wr_ptr), 32'd4);
    chk("wr_pops", 32'(pops), 32'd4);
    chk("wr_q", 32'(exp_q.size()), 32'd0);

    // Stray read data outside RD_WAIT.
    @(posedge clk); #1;
    man_valid = 1'b1;
    @(negedge clk);
    chk("stray_done", 32'(rd_done), 32'd0);
    @(posedge clk); #1;
    man_valid = 1'b0;
    chk("stray_state", 32'(state), 32'(IDLE));

    // Read gated by empty ring.
    rd_addr = 4'd4;
    rd_req = 1'b1;
    @(negedge clk);
    chk("empty_1", 32'(rd_empty), 32'd1);
    repeat (3) @(negedge clk);
    chk("empty_idle", 32'(state), 32'(IDLE));
    @(posedge clk); #1;
    rd_addr = 4'd2;
    push_rd(2);
    @(negedge clk);
    chk("empty_0", 32'(rd_empty), 32'd0);
    @(posedge clk); #1;
    rd_req = 1'b0;
    wait_st(RD_WAIT, 5, "rd_wait");
    chk("rd_done_early", 32'(rd_done), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    man_valid = 1'b1;
    @(negedge clk);
    chk("rd_done", 32'(rd_done), 32'd1);
    chk("rd_done_st", 32'(state), 32'(RD_WAIT));
    @(posedge clk); #1;
    man_valid = 1'b0;
    chk("rd_turn", 32'(state), 32'(TURN));
    wait_st(IDLE, 3, "rd_idle");

    // Fairness: W R W R, write first.
    @(posedge clk); #1;
    auto_rsp = 1'b1;
    rd_addr = 4'd2;
    wr_fill = 8'd5;
    wr_req = 1'b1;
    rd_req = 1'b1;
    push_wr(4);
    push_rd(2);
    push_wr(8);
    push_rd(2);
    drain(60, "fair_drain");
    wr_req = 1'b0;
    rd_req = 1'b0;
    wait_st(IDLE, 6, "fair_idle");
    chk("fair_ptr", 32'(wr_ptr), 32'd12);

    // Backpressure with pointer wrap.
    @(posedge clk); #1;
    wr_fill = 8'd4;
    wr_req = 1'b1;
    dram_cmd_ready = 1'b0;
    push_wr(12);
    @(posedge clk); #1;
    wr_req = 1'b0;
    for (int n = 0; n < 30 && exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
      dram_cmd_ready = ~dram_cmd_ready;
    end
    chk("bp_drain", 32'(exp_q.size()), 32'd0);
    dram_cmd_ready = 1'b1;
    wait_st(IDLE, 6, "bp_idle");
    chk("bp_wrap", 32'(wr_ptr), 32'd0);

    // High-water priority over a pending read.
    @(posedge clk); #1;
    rd_addr = 4'd10;
    rd_req = 1'b1;
    wr_req = 1'b1;
    wr_fill = 8'd8;
    push_wr(0);
    push_wr(4);
    drain(40, "pri_drain_w");
    wr_fill = 8'd7;
    push_rd(10);
    drain(20, "pri_drain_r");
    wr_req = 1'b0;
    rd_req = 1'b0;
    wait_st(IDLE, 6, "pri_idle");
    chk("pri_ptr", 32'(wr_ptr), 32'd8);

    // Async reset in the middle of a burst.
    @(posedge clk); #1;
    wr_fill = 8'd4;
    wr_req = 1'b1;
    push_wr(8);
    @(posedge clk); #1;
    wr_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("mid_valid", 32'(dram_cmd_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_state", 32'(state), 32'(IDLE));
    chk("ar_valid", 32'(dram_cmd_valid), 32'd0);
    chk("ar_pop", 32'(wr_pop), 32'd0);
    chk("ar_addr", 32'(dram_cmd_addr), 32'd0);
    chk("ar_ptr", 32'(wr_ptr), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ar_idle", 32'(state), 32'(IDLE));

    // Read with no data; wr_req must not preempt the wait.
    auto_rsp = 1'b0;
    @(posedge clk); #1;
    rd_addr = 4'd5;
    rd_req = 1'b1;
    push_rd(5);
    @(posedge clk); #1;
    rd_req = 1'b0;
    wait_st(RD_WAIT, 5, "nw_wait");
    wr_fill = 8'd9;
    wr_req = 1'b1;
    push_wr(0);
`ifdef DRAM_RD_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("to_err", 32'(rd_err), 32'(k == 10));
      chk("to_done", 32'(rd_done), 32'd0);
    end
    @(negedge clk);
    chk("to_turn", 32'(state), 32'(TURN));
`else
    repeat (20) @(negedge clk);
    chk("nw_hold", 32'(state), 32'(RD_WAIT));
    @(posedge clk); #1;
    man_valid = 1'b1;
    @(negedge clk);
    chk("nw_done", 32'(rd_done), 32'd1);
    @(posedge clk); #1;
    man_valid = 1'b0;
`endif
    wait_st(WR_BURST, 6, "nw_burst");
    @(posedge clk); #1;
    wr_req = 1'b0;
    drain(10, "nw_drain");
    wait_st(IDLE, 6, "nw_idle");
    chk("nw_ptr", 32'(wr_ptr), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
